// File: rtl/ysyx_23060061_mem_responder.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY cycles,
// performs a masked write or a read on word-addressed storage, then holds the response.
module ysyx_23060061_mem_responder #(
  parameter logic [31:0] BASE       = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam logic [32:0] LIMIT  = {1'b0, BASE} + (33'd1 << (DEPTH_LOG2 + 2));
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  stateT state, stateNext;
  logic [3:0]  count;

  logic        latWen;
  logic [31:0] latAddr;
  logic [31:0] latWdata;
  logic [3:0]  latWmask;

  logic        accWen;
  logic [31:0] accAddr;
  logic [31:0] accWdata;
  logic [3:0]  accWmask;
  logic [DEPTH_LOG2-1:0] accIdx;

  logic        accept;
  logic        commit;
  logic        inRange;
  logic [31:0] rspRdataQ;
  logic        rspErrQ;

  logic [31:0] mem [DEPTH];

  assign accept = req_valid && (state == IDLE);

  // With LATENCY == 1 the access happens on the accept edge itself, so it must
  // see the live request rather than the not-yet-loaded latch.
  always_comb begin
    if (state == IDLE) begin
      accWen   = req_wen;
      accAddr  = req_addr;
      accWdata = req_wdata;
      accWmask = req_wmask;
    end else begin
      accWen   = latWen;
      accAddr  = latAddr;
      accWdata = latWdata;
      accWmask = latWmask;
    end
  end

  assign commit  = (accept && (LATENCY == 1)) || ((state == WAIT) && (count == 4'd1));
  assign inRange = (accAddr >= BASE) && ({1'b0, accAddr} < LIMIT);
  assign accIdx  = DEPTH_LOG2'((accAddr - BASE) >> 2);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        count <= LAT_M1;
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (req_valid) stateNext = (LATENCY > 1) ? WAIT : RESP;
      WAIT: if (count == 4'd1) stateNext = RESP;
      RESP: if (rsp_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rspRdataQ;
    rsp_err   = rspErrQ;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      latWen   <= req_wen;
      latAddr  <= req_addr;
      latWdata <= req_wdata;
      latWmask <= req_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rspRdataQ <= '0;
      rspErrQ   <= 1'b0;
    end else if (commit) begin
      rspRdataQ <= (!accWen && inRange) ? mem[accIdx] : '0;
      rspErrQ   <= !inRange;
    end else if ((state == RESP) && rsp_ready) begin
      rspRdataQ <= '0;
      rspErrQ   <= 1'b0;
    end
  end

  // Storage is deliberately not reset; rst only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && accWen && inRange) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (accWmask[i]) mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
      end
    end
  end

endmodule
